// File: rtl/ddram_arbiter.sv
// Round-robin arbiter sharing the ddram single-client port; IDLE->strobe 1 cycle, ack >=4 cycles after request.
// Requests are level-held until req_ack; the winner's operands stay latched while the wrapper is busy.
module ddram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter bit PRIO0   = 1'b0,
  parameter int TIMEOUT = 1023
) (
  input  logic                  DDRAM_CLK,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ*27-1:0] req_addr,
  input  logic [NUM_REQ*64-1:0] req_din,
  input  logic [NUM_REQ*8-1:0]  req_burst,
  input  logic [NUM_REQ-1:0]    req_ch,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    req_dready,
  output logic [2:0]            grant,
  output logic                  timeout_err,
  output logic [26:0]           mem_addr,
  output logic [63:0]           mem_din,
  output logic [7:0]            mem_burst,
  output logic                  mem_rd_ch,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic                  mem_busy,
  input  logic                  mem_dready
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACCEPT, DONE} state_e;

  typedef struct packed {
    logic [26:0] addr;
    logic [63:0] din;
    logic [7:0]  burst;
    logic        ch;
  } mem_op_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_e             state_q, state_d;
  mem_op_t            op_q, sel_op;
  logic [2:0]         ptr_q, win;
  logic               op_wr_q;
  logic [9:0]         to_cnt_q, to_cnt_d;
  logic               latch, fin, to_fire, to_hit, waiting;
  logic [NUM_REQ-1:0] req_any, ack_d;
  int                 idx;
  logic               found;

  assign req_any = req_rd | req_wr;
  assign waiting = (state_q == ACCEPT) || (state_q == DONE);
  assign to_hit  = (to_cnt_q == TO_LAST);

  // Search starts one past the last winner so every client gets a turn.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_any[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
    if (PRIO0 && req_any[0]) win = 3'd0;
  end

  always_comb begin
    sel_op.addr  = req_addr[27*int'(win) +: 27];
    sel_op.din   = req_din[64*int'(win) +: 64];
    sel_op.burst = req_burst[8*int'(win) +: 8];
    sel_op.ch    = req_ch[int'(win)];
  end

  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    fin     = 1'b0;
    to_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_any) begin
          latch   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = ACCEPT;
      ACCEPT: begin
        if (mem_busy) begin
          state_d = DONE;
        end else if (to_hit) begin
          to_fire = 1'b1;
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (!mem_busy) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if (to_hit) begin
          to_fire = 1'b1;
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every state change, so each wait state gets its own budget.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_d != state_q) to_cnt_d = '0;
    else if (waiting)       to_cnt_d = to_cnt_q + 10'd1;
  end

  always_comb begin
    ack_d      = '0;
    req_dready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      ack_d[k]      = fin && (grant == 3'(k));
      req_dready[k] = waiting && !op_wr_q && (grant == 3'(k)) && mem_dready;
    end
  end

  assign mem_wr    = (state_q == ISSUE) && op_wr_q;
  assign mem_rd    = (state_q == ISSUE) && !op_wr_q;
  assign mem_addr  = op_q.addr;
  assign mem_din   = op_q.din;
  assign mem_burst = op_q.burst;
  assign mem_rd_ch = op_q.ch;

  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      op_q        <= '0;
      op_wr_q     <= 1'b0;
      grant       <= 3'd0;
      ptr_q       <= 3'd0;
      req_ack     <= '0;
      timeout_err <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      req_ack  <= ack_d;
      to_cnt_q <= to_cnt_d;
      if (latch) begin
        op_q    <= sel_op;
        grant   <= win;
        op_wr_q <= req_wr[int'(win)];
      end
      if (fin)     ptr_q       <= grant;
      if (to_fire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Bench for ddram_arbiter: wrapper model per instance plus a scoreboard of expected issues and acks.
`timescale 1ns/1ps
module tb_ddram_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [N-1:0]     req_rd, req_wr, req_rd1, req_wr1, req_ch;
  logic [N*27-1:0]  req_addr;
  logic [N*64-1:0]  req_din;
  logic [N*8-1:0]   req_burst;
  logic [N-1:0]     ack [2];
  logic [N-1:0]     dready [2];
  logic [2:0]       grant [2];
  logic             terr [2];
  logic [26:0]      maddr [2];
  logic [63:0]      mdin [2];
  logic [7:0]       mburst [2];
  logic             mch [2], mrd [2], mwr [2], busy [2], mdr [2];

  ddram_arbiter #(.NUM_REQ(N), .PRIO0(1'b0), .TIMEOUT(16)) u_rr (
    .DDRAM_CLK(clk), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
    .req_burst(req_burst), .req_ch(req_ch), .req_ack(ack[0]), .req_dready(dready[0]),
    .grant(grant[0]), .timeout_err(terr[0]), .mem_addr(maddr[0]), .mem_din(mdin[0]),
    .mem_burst(mburst[0]), .mem_rd_ch(mch[0]), .mem_rd(mrd[0]), .mem_wr(mwr[0]),
    .mem_busy(busy[0]), .mem_dready(mdr[0]));

  ddram_arbiter #(.NUM_REQ(N), .PRIO0(1'b1), .TIMEOUT(16)) u_prio (
    .DDRAM_CLK(clk), .reset_n(reset_n),
    .req_rd(req_rd1), .req_wr(req_wr1), .req_addr(req_addr), .req_din(req_din),
    .req_burst(req_burst), .req_ch(req_ch), .req_ack(ack[1]), .req_dready(dready[1]),
    .grant(grant[1]), .timeout_err(terr[1]), .mem_addr(maddr[1]), .mem_din(mdin[1]),
    .mem_burst(mburst[1]), .mem_rd_ch(mch[1]), .mem_rd(mrd[1]), .mem_wr(mwr[1]),
    .mem_busy(busy[1]), .mem_dready(mdr[1]));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ack_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Wrapper model: busy rises the cycle after a strobe edge and holds busy_len cycles.
  logic stq [2];
  int   bleft [2], dleft [2];
  int   nwr [2] = '{0, 0};
  int   busy_len [2];
  bit   no_busy [2];

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        stq[k] <= 1'b0; busy[k] <= 1'b0; bleft[k] <= 0; dleft[k] <= 0; mdr[k] <= 1'b0;
      end else begin
        stq[k] <= mrd[k] | mwr[k];
        mdr[k] <= 1'b0;
        if ((mrd[k] | mwr[k]) && !stq[k]) begin
          if (!no_busy[k]) begin
            busy[k]  <= 1'b1;
            bleft[k] <= busy_len[k] - 1;
            dleft[k] <= mrd[k] ? int'(mburst[k]) : 0;
          end
          if (mwr[k]) nwr[k] <= nwr[k] + 1;
        end else if (busy[k]) begin
          if (bleft[k] == 0) busy[k] <= 1'b0;
          else bleft[k] <= bleft[k] - 1;
          if (dleft[k] != 0) begin
            mdr[k]   <= 1'b1;
            dleft[k] <= dleft[k] - 1;
          end
        end
      end
    end
  end

  typedef struct {
    int          cl;
    bit          wr;
    logic [26:0] addr;
    logic [63:0] din;
    logic [7:0]  burst;
    bit          ch;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   q1[$];
  exp_t e_m;
  int   a_m;
  int   cur_rd = -1;
  int   dr_cnt0 = 0;
  bit   prev_st = 1'b0;
  int   rem [2][N];

  // Scoreboard for the round-robin instance: issues and acks are popped as they appear.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_st = 1'b0;
    end else begin
      if (mrd[0] | mwr[0]) begin
        chk("strobe_gap", 64'(prev_st), 0);
        if (exp_q.size() == 0) begin
          chk("issue_unexpected", 1, 0);
        end else begin
          e_m = exp_q.pop_front();
          chk("grant", grant[0], e_m.cl);
          chk("op_wr", 64'(mwr[0]), 64'(e_m.wr));
          chk("addr", maddr[0], e_m.addr);
          if (e_m.wr) begin
            chk("din", mdin[0], e_m.din);
          end else begin
            chk("burst", mburst[0], e_m.burst);
            chk("rd_ch", 64'(mch[0]), 64'(e_m.ch));
            cur_rd = e_m.cl;
          end
          ack_q.push_back(e_m.cl);
        end
      end
      prev_st = mrd[0] | mwr[0];
      if (dready[0] != 0 || mdr[0])
        chk("dready", dready[0], (cur_rd >= 0) ? (64'(mdr[0]) << cur_rd) : 64'(0));
      if (dready[0][0]) dr_cnt0++;
      if (ack[0] != 0) begin
        if (ack_q.size() == 0) begin
          chk("ack_unexpected", ack[0], 0);
        end else begin
          a_m = ack_q.pop_front();
          chk("ack", ack[0], 64'(1) << a_m);
        end
        cur_rd = -1;
      end
    end
  end

  task automatic set_req(input int inst, input int c, input bit wr, input logic [26:0] a,
                         input logic [63:0] d, input logic [7:0] b, input bit ch);
    req_addr[27*c +: 27] = a;
    req_din[64*c +: 64]  = d;
    req_burst[8*c +: 8]  = b;
    req_ch[c]            = ch;
    if (inst == 0) begin
      req_wr[c] = wr;
      req_rd[c] = !wr;
    end else begin
      req_wr1[c] = 1'b1;
    end
  endtask

  task automatic push0(input int c, input bit wr, input logic [26:0] a,
                       input logic [63:0] d, input logic [7:0] b, input bit ch);
    exp_t e;
    e.cl = c; e.wr = wr; e.addr = a; e.din = d; e.burst = b; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic issue0(input int c, input bit wr, input logic [26:0] a,
                        input logic [63:0] d, input logic [7:0] b, input bit ch);
    set_req(0, c, wr, a, d, b, ch);
    push0(c, wr, a, d, b, ch);
    rem[0][c] = 1;
  endtask

  // Drops each client's request once its remaining ack count reaches zero.
  task automatic wait_acks(input int inst, input int budget);
    int left;
    int e;
    left = 0;
    for (int i = 0; i < N; i++) left += rem[inst][i];
    while (left > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (ack[inst] != 0) begin
        last_ack_cyc = cyc;
        if (inst == 1) begin
          if (q1.size() == 0) begin
            chk("prio_ack_unexpected", ack[1], 0);
          end else begin
            e = q1.pop_front();
            chk("prio_ack", ack[1], 64'(1) << e);
            chk("prio_grant", grant[1], e);
          end
        end
        for (int i = 0; i < N; i++) begin
          if (ack[inst][i] && rem[inst][i] > 0) begin
            rem[inst][i]--;
            left--;
            if (rem[inst][i] == 0) begin
              if (inst == 0) begin req_rd[i] = 1'b0; req_wr[i] = 1'b0; end
              else req_wr1[i] = 1'b0;
            end
          end
        end
      end
    end
    chk("ack_budget", left, 0);
  endtask

  task automatic wait_strobe(input int budget, output int at_cyc);
    at_cyc = -1;
    while (budget > 0 && at_cyc < 0) begin
      @(negedge clk);
      budget--;
      if (mwr[0] | mrd[0]) at_cyc = cyc;
    end
    chk("strobe_budget", 64'(at_cyc < 0), 0);
  endtask

  initial begin
    int t0, s_cyc, n0, d0;
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; req_rd1 = '0; req_wr1 = '0; req_ch = '0;
    req_addr = '0; req_din = '0; req_burst = '0;
    busy_len = '{1, 1};
    no_busy  = '{1'b0, 1'b0};
    for (int k = 0; k < 2; k++) for (int i = 0; i < N; i++) rem[k][i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {ack[0], dready[0], grant[0], terr[0], mrd[0], mwr[0], mch[0]}, 0);
    chk("rst_mem", {maddr[0], mburst[0]}, 0);
    chk("rst_din", mdin[0], 0);
    reset_n = 1'b1;
    @(negedge clk);

    // single write from client 1, minimum-latency wrapper
    issue0(1, 1'b1, 27'h0001234, 64'hDEADBEEF_CAFEF00D, 8'd0, 1'b0);
    t0 = cyc;
    wait_acks(0, 50);
    chk("wr_latency", last_ack_cyc - t0, 4);
    @(negedge clk);
    chk("ack_width", ack[0], 0);
    chk("wr_count", nwr[0], 1);

    // read burst 4 from client 0 on channel 1
    busy_len[0] = 6;
    d0 = dr_cnt0;
    issue0(0, 1'b0, 27'h0ABCDE0, 64'h0, 8'd4, 1'b1);
    wait_acks(0, 50);
    chk("rd_beats", dr_cnt0 - d0, 4);

    // wrapper never goes busy: timeout after 16 cycles in ACCEPT
    busy_len[0] = 1;
    no_busy[0]  = 1'b1;
    issue0(1, 1'b1, 27'h0000040, 64'h0123_4567_89AB_CDEF, 8'd0, 1'b0);
    wait_strobe(10, s_cyc);
    repeat (16) @(negedge clk);
    chk("terr_early", 64'(terr[0]), 0);
    wait_acks(0, 5);
    chk("terr_set", 64'(terr[0]), 1);
    chk("to_latency", last_ack_cyc - s_cyc, 17);
    no_busy[0] = 1'b0;

    // back-to-back writes from client 2
    n0 = nwr[0];
    issue0(2, 1'b1, 27'h0000100, 64'h1111, 8'd0, 1'b0);
    wait_acks(0, 50);
    issue0(2, 1'b1, 27'h0000108, 64'h2222, 8'd0, 1'b0);
    wait_acks(0, 50);
    chk("b2b_writes", nwr[0] - n0, 2);
    chk("terr_sticky", 64'(terr[0]), 1);

    // all three held continuously; last winner was 2 so order is 0,1,2,0,1,2
    for (int c = 0; c < N; c++) begin
      set_req(0, c, 1'b1, 27'(32'h200 + c * 8), 64'(32'hA000 + c), 8'd0, 1'b0);
      rem[0][c] = 2;
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++)
        push0(c, 1'b1, 27'(32'h200 + c * 8), 64'(32'hA000 + c), 8'd0, 1'b0);
    wait_acks(0, 200);

    // reset while the wrapper is busy in DONE
    busy_len[0] = 8;
    issue0(0, 1'b1, 27'h7FFFFFF, 64'hFFFF_0000_FFFF_0000, 8'd0, 1'b0);
    wait_strobe(10, s_cyc);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ctrl", {ack[0], dready[0], grant[0], terr[0], mrd[0], mwr[0], mch[0]}, 0);
    chk("arst_mem", {maddr[0], mburst[0]}, 0);
    chk("arst_din", mdin[0], 0);
    exp_q.delete();
    ack_q.delete();
    cur_rd = -1;
    rem[0][0] = 0;
    req_rd = '0;
    req_wr = '0;
    @(negedge clk);
    reset_n = 1'b1;
    busy_len[0] = 1;
    @(negedge clk);
    issue0(1, 1'b1, 27'h0055AA0, 64'h5A5A_5A5A_A5A5_A5A5, 8'd0, 1'b0);
    wait_acks(0, 50);

    // fixed-priority instance: client 0 wins while held, then round-robin resumes
    set_req(1, 0, 1'b1, 27'h300, 64'h30, 8'd0, 1'b0);
    set_req(1, 1, 1'b1, 27'h308, 64'h31, 8'd0, 1'b0);
    set_req(1, 2, 1'b1, 27'h310, 64'h32, 8'd0, 1'b0);
    rem[1][0] = 3; rem[1][1] = 1; rem[1][2] = 1;
    q1 = '{0, 0, 0, 1, 2};
    wait_acks(1, 200);
    chk("prio_left", q1.size(), 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
